seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Downstream display stage for the BCD digit counter. Takes up to four BCD digits plus decimal points and time-multiplexes them onto one shared 7-segment bus with one-hot digit enables. Inserts a blanking gap between digits to prevent ghosting and supports optional leading-zero blanking. Latches its inputs once per frame so the display never tears.

Parameters:
DWELL_CYCLES, 10_000, clocks each digit is lit (1 ms at 10 MHz); legal range 1..2^24-1
BLANK_CYCLES, 100, clocks of all-off gap after each digit; 0 means no gap; legal range 0..2^24-1
COMMON_ANODE, 0, 1 inverts segments and dp (active-low); digit_sel is always active-high

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  scan enable; low forces idle with display dark
digits_in  input  16  four BCD digits; [3:0]=digit0 (least significant) .. [15:12]=digit3
dp_in  input  4  decimal point per digit; bit k goes with digit k
lzb_en  input  1  leading-zero blanking enable
segments  output  7  segment drive; bit0=a .. bit6=g
dp  output  1  decimal point drive
digit_sel  output  4  one-hot digit enable; bit k = digit k
frame_start  output  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- All outputs are registered.
- On reset, asserted asynchronously:
  - segments = all off (7'h00, or 7'h7F if COMMON_ANODE)
  - dp off; digit_sel = 0; frame_start = 0
  - state IDLE; index = 0; counters = 0; shadow registers = 0
- States: IDLE, SHOW, BLANK.
- IDLE: outputs dark.
  - On the first edge with ena=1: snapshot digits_in/dp_in/lzb_en into shadow registers, go to SHOW with index=0, and set frame_start=1 for exactly one cycle.
- SHOW: digit_sel = 1<<index; segments and dp come from shadow digit[index].
  - SHOW lasts exactly DWELL_CYCLES cycles, then the block enters BLANK.
  - If BLANK_CYCLES=0, it skips BLANK and advances directly.
- BLANK: digit_sel = 0; segments and dp off; lasts exactly BLANK_CYCLES cycles. Then it advances:
  - index = index+1 mod 4, then back to SHOW.
  - On wrap from 3 to 0: new snapshot plus a frame_start pulse, coincident with the first cycle of digit0 SHOW.
- Frame period = 4*(DWELL_CYCLES+BLANK_CYCLES) cycles, exactly.
- ena=0 in any state: next edge goes to IDLE with outputs dark and counters/index cleared. Re-enable restarts at digit0 with a fresh snapshot.
- Decode, shown as g..a with 1 = lit:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - codes 10..15 = 1000000 (dash)
- Leading-zero blanking (shadow lzb_en=1):
  - Digit k (k>=1) is blanked if it and every higher digit equal 0.
  - digit0 is never blanked.
  - A blanked digit keeps its digit_sel slot and timing but drives segments off.
  - Its dp still follows dp_in.
- COMMON_ANODE=1 inverts segments and dp in every state, including reset and IDLE.
- Input changes mid-frame have no effect until the next snapshot.
- Dwell and blank counters are 24-bit and must not wrap within a phase.

Test Plan:
- DWELL=4, BLANK=2, digits_in=16'h1234, ena=1 -> digit_sel sequence:
  - 0001 with 1100110 ("4") for 4 cycles, then 0000 for 2 cycles
  - 0010 "3", 0100 "2", 1000 "1"
  - frame_start pulses every 24 cycles.
- digits_in=16'h0050, lzb_en=1 -> digits 3 and 2 show 0000000, digit1 shows 1101101, digit0 shows 0111111. With lzb_en=0, digits 3 and 2 show 0111111.
- Change digits_in from 16'h1234 to 16'h9876 while digit1 is lit -> remaining digits of the frame still show 1234; the 9876 values appear only after the next frame_start.
- digits_in=16'h00AF, COMMON_ANODE=1 -> digit0 and digit1 segments both = 0111111 (inverted dash); idle segments = 1111111.
- Drop ena mid-SHOW of digit2 -> next cycle digit_sel=0 and segments dark. Re-raise ena -> digit0 lights one cycle later with frame_start=1.
- Assert rst_n=0 asynchronously mid-dwell -> all outputs reach reset values before the next clock edge. After release with ena=1, the scan restarts at digit0.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - digit/segment bus between a display source and the scan driver
interface seg7_scan_driver_if;
  logic        ena;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        lzb_en;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  digit_sel;
  logic        frame_start;

  modport master (
    output ena, digits_in, dp_in, lzb_en,
    input  segments, dp, digit_sel, frame_start
  );

  modport slave (
    input  ena, digits_in, dp_in, lzb_en,
    output segments, dp, digit_sel, frame_start
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - four-digit 7-segment scan driver with blanking gap and leading-zero blanking
module seg7_scan_driver #(
  parameter int DWELL_CYCLES = 10_000,
  parameter int BLANK_CYCLES = 100,
  parameter bit COMMON_ANODE = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_driver_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  localparam logic [23:0] DWELL_LAST = 24'(DWELL_CYCLES - 1);
  localparam logic [23:0] BLANK_LAST = 24'(BLANK_CYCLES - 1);
  localparam logic [6:0]  SEG_OFF    = {7{COMMON_ANODE}};

  state_t      state, state_n;
  logic [1:0]  idx, idx_n;
  logic [23:0] cnt, cnt_n;
  logic [15:0] sh_digits, sh_digits_n;
  logic [3:0]  sh_dp, sh_dp_n;
  logic        sh_lzb, sh_lzb_n;

  logic [6:0]  seg_q, seg_n;
  logic        dp_q, dp_n;
  logic [3:0]  sel_q, sel_n;
  logic        fs_q, fs_n;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000;
    endcase
  endfunction

  // A digit is a leading zero when it and every more significant digit are zero.
  function automatic logic is_leading_zero(input logic [15:0] d, input logic [1:0] k);
    case (k)
      2'd1:    is_leading_zero = (d[15:4] == 12'h000);
      2'd2:    is_leading_zero = (d[15:8] == 8'h00);
      2'd3:    is_leading_zero = (d[15:12] == 4'h0);
      default: is_leading_zero = 1'b0;
    endcase
  endfunction

  always_comb begin
    logic snap;
    logic advance;
    logic [3:0] nib;
    logic [6:0] seg_raw;
    logic dp_raw;

    state_n     = state;
    idx_n       = idx;
    cnt_n       = cnt;
    sh_digits_n = sh_digits;
    sh_dp_n     = sh_dp;
    sh_lzb_n    = sh_lzb;
    fs_n        = 1'b0;
    snap        = 1'b0;
    advance     = 1'b0;
    nib         = 4'h0;
    seg_raw     = 7'h00;
    dp_raw      = 1'b0;

    if (!bus.ena) begin
      state_n = IDLE;
      idx_n   = 2'd0;
      cnt_n   = 24'd0;
    end else begin
      case (state)
        IDLE: begin
          state_n = SHOW;
          idx_n   = 2'd0;
          cnt_n   = 24'd0;
          snap    = 1'b1;
        end
        SHOW: begin
          if (cnt == DWELL_LAST) begin
            cnt_n = 24'd0;
            if (BLANK_CYCLES == 0) advance = 1'b1;
            else                   state_n = BLANK;
          end else begin
            cnt_n = cnt + 24'd1;
          end
        end
        BLANK: begin
          if (cnt == BLANK_LAST) advance = 1'b1;
          else                   cnt_n = cnt + 24'd1;
        end
        default: state_n = IDLE;
      endcase

      if (advance) begin
        state_n = SHOW;
        cnt_n   = 24'd0;
        idx_n   = idx + 2'd1;
        snap    = (idx == 2'd3);
      end

      if (snap) begin
        sh_digits_n = bus.digits_in;
        sh_dp_n     = bus.dp_in;
        sh_lzb_n    = bus.lzb_en;
        fs_n        = 1'b1;
      end
    end

    // Outputs are derived from the next state so they register alongside it.
    sel_n = 4'b0000;
    if (state_n == SHOW) begin
      sel_n  = 4'b0001 << idx_n;
      nib    = sh_digits_n[{idx_n, 2'b00} +: 4];
      dp_raw = sh_dp_n[idx_n];
      if (!(sh_lzb_n && is_leading_zero(sh_digits_n, idx_n)))
        seg_raw = decode(nib);
    end
    seg_n = seg_raw ^ {7{COMMON_ANODE}};
    dp_n  = dp_raw ^ COMMON_ANODE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= 24'd0;
      sh_digits <= 16'h0000;
      sh_dp     <= 4'h0;
      sh_lzb    <= 1'b0;
      seg_q     <= SEG_OFF;
      dp_q      <= COMMON_ANODE;
      sel_q     <= 4'b0000;
      fs_q      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      sh_digits <= sh_digits_n;
      sh_dp     <= sh_dp_n;
      sh_lzb    <= sh_lzb_n;
      seg_q     <= seg_n;
      dp_q      <= dp_n;
      sel_q     <= sel_n;
      fs_q      <= fs_n;
    end
  end

  assign bus.segments    = seg_q;
  assign bus.dp          = dp_q;
  assign bus.digit_sel   = sel_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized bench for seg7_scan_driver against a frame-position model
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dpin = 4'h0;
  logic        lzb = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seg7_scan_driver_if bus0();
  seg7_scan_driver_if bus1();

  assign bus0.ena = ena;  assign bus0.digits_in = digits;  assign bus0.dp_in = dpin;  assign bus0.lzb_en = lzb;
  assign bus1.ena = ena;  assign bus1.digits_in = digits;  assign bus1.dp_in = dpin;  assign bus1.lzb_en = lzb;

  seg7_scan_driver #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .COMMON_ANODE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  seg7_scan_driver #(.DWELL_CYCLES(3), .BLANK_CYCLES(0), .COMMON_ANODE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  localparam int MD[2]  = '{4, 3};
  localparam int MB[2]  = '{2, 0};
  localparam bit MCA[2] = '{1'b0, 1'b1};
  localparam logic [6:0] DEC[16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111,
    7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};

  // Model: position within the frame plus the snapshot taken at position 0.
  bit          m_act[2];
  int          m_pos[2];
  logic [15:0] m_d[2];
  logic [3:0]  m_dp[2];
  bit          m_lzb[2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_act[i] <= 1'b0; m_pos[i] <= 0; m_d[i] <= '0; m_dp[i] <= '0; m_lzb[i] <= 1'b0;
      end else if (!ena) begin
        m_act[i] <= 1'b0; m_pos[i] <= 0;
      end else if (!m_act[i] || ((m_pos[i] + 1) % (4 * (MD[i] + MB[i])) == 0)) begin
        m_act[i] <= 1'b1; m_pos[i] <= 0; m_d[i] <= digits; m_dp[i] <= dpin; m_lzb[i] <= lzb;
      end else begin
        m_pos[i] <= m_pos[i] + 1;
      end
    end
  end

  function automatic bit e_lit(int i);
    return m_act[i] && ((m_pos[i] % (MD[i] + MB[i])) < MD[i]);
  endfunction

  function automatic int e_slot(int i);
    return m_pos[i] / (MD[i] + MB[i]);
  endfunction

  function automatic logic [3:0] e_sel(int i);
    logic [3:0] s;
    s = 4'b0000;
    if (e_lit(i)) s[e_slot(i)] = 1'b1;
    return s;
  endfunction

  function automatic logic [6:0] e_seg(int i);
    logic [6:0] s;
    logic [15:0] upper;
    int k;
    s = 7'h00;
    if (e_lit(i)) begin
      k = e_slot(i);
      upper = m_d[i] >> (4 * k);
      if (!(m_lzb[i] && k > 0 && upper == 16'h0000)) s = DEC[upper[3:0]];
    end
    return MCA[i] ? ~s : s;
  endfunction

  function automatic logic e_dp(int i);
    logic d;
    d = e_lit(i) ? m_dp[i][e_slot(i)] : 1'b0;
    return d ^ MCA[i];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("dut0 segments",    32'(bus0.segments),    32'(e_seg(0)));
    chk("dut0 dp",          32'(bus0.dp),          32'(e_dp(0)));
    chk("dut0 digit_sel",   32'(bus0.digit_sel),   32'(e_sel(0)));
    chk("dut0 frame_start", 32'(bus0.frame_start), 32'(m_act[0] && m_pos[0] == 0));
    chk("dut1 segments",    32'(bus1.segments),    32'(e_seg(1)));
    chk("dut1 dp",          32'(bus1.dp),          32'(e_dp(1)));
    chk("dut1 digit_sel",   32'(bus1.digit_sel),   32'(e_sel(1)));
    chk("dut1 frame_start", 32'(bus1.frame_start), 32'(m_act[1] && m_pos[1] == 0));
  end

  task automatic wn(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int r;
    logic [15:0] mask;

    wn(2);
    chk("reset seg0", 32'(bus0.segments), 32'h00);
    chk("reset sel0", 32'(bus0.digit_sel), 32'h0);
    chk("reset fs0",  32'(bus0.frame_start), 32'h0);
    chk("reset seg1", 32'(bus1.segments), 32'h7F);
    chk("reset dp1",  32'(bus1.dp), 32'h1);
    rst_n = 1'b1;
    wn(2);

    digits = 16'h1234; ena = 1'b1;
    wn(1);
    chk("1234 d0 sel", 32'(bus0.digit_sel), 32'b0001);
    chk("1234 d0 seg", 32'(bus0.segments), 32'b1100110);
    chk("1234 fs",     32'(bus0.frame_start), 32'h1);
    chk("1234 ca seg", 32'(bus1.segments), 32'b0011001);
    wn(1);
    chk("1234 fs off", 32'(bus0.frame_start), 32'h0);
    wn(3);
    chk("1234 gap sel", 32'(bus0.digit_sel), 32'b0000);
    chk("1234 gap seg", 32'(bus0.segments), 32'h00);
    wn(2);
    chk("1234 d1 sel", 32'(bus0.digit_sel), 32'b0010);
    chk("1234 d1 seg", 32'(bus0.segments), 32'b1001111);
    digits = 16'h9876;
    wn(6);
    chk("tear d2 sel", 32'(bus0.digit_sel), 32'b0100);
    chk("tear d2 seg", 32'(bus0.segments), 32'b1011011);
    wn(6);
    chk("tear d3 seg", 32'(bus0.segments), 32'b0000110);
    wn(6);
    chk("9876 fs",     32'(bus0.frame_start), 32'h1);
    chk("9876 d0 seg", 32'(bus0.segments), 32'b1111101);

    ena = 1'b0; digits = 16'h0050; lzb = 1'b1;
    wn(1);
    chk("idle sel", 32'(bus0.digit_sel), 32'h0);
    ena = 1'b1;
    wn(1);
    chk("lzb d0 seg", 32'(bus0.segments), 32'b0111111);
    wn(6);
    chk("lzb d1 seg", 32'(bus0.segments), 32'b1101101);
    wn(6);
    chk("lzb d2 sel", 32'(bus0.digit_sel), 32'b0100);
    chk("lzb d2 seg", 32'(bus0.segments), 32'h00);
    wn(1);
    ena = 1'b0; lzb = 1'b0;
    wn(1);
    chk("drop sel", 32'(bus0.digit_sel), 32'h0);
    chk("drop seg", 32'(bus0.segments), 32'h00);
    ena = 1'b1;
    wn(1);
    chk("reen sel", 32'(bus0.digit_sel), 32'b0001);
    chk("reen fs",  32'(bus0.frame_start), 32'h1);
    wn(12);
    chk("nolzb d2 seg", 32'(bus0.segments), 32'b0111111);
    wn(6);
    chk("nolzb d3 seg", 32'(bus0.segments), 32'b0111111);

    ena = 1'b0; digits = 16'h00AF;
    wn(1);
    chk("ca idle seg", 32'(bus1.segments), 32'h7F);
    ena = 1'b1;
    wn(1);
    chk("ca d0 sel", 32'(bus1.digit_sel), 32'b0001);
    chk("ca d0 seg", 32'(bus1.segments), 32'b0111111);
    chk("cc dash",   32'(bus0.segments), 32'b1000000);
    wn(3);
    chk("ca d1 sel", 32'(bus1.digit_sel), 32'b0010);
    chk("ca d1 seg", 32'(bus1.segments), 32'b0111111);

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async sel0", 32'(bus0.digit_sel), 32'h0);
    chk("async seg1", 32'(bus1.segments), 32'h7F);
    chk("async sel1", 32'(bus1.digit_sel), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wn(1);
    chk("post rst sel", 32'(bus0.digit_sel), 32'b0001);
    chk("post rst fs",  32'(bus0.frame_start), 32'h1);

    repeat (3000) begin
      @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 4) begin
        case ($urandom_range(0, 2))
          0:       mask = 16'hFFFF;
          1:       mask = 16'h00FF;
          default: mask = 16'h000F;
        endcase
        digits = 16'($urandom) & mask;
      end
      if (r >= 10 && r < 14) dpin = 4'($urandom);
      if (r == 20) lzb = ~lzb;
      if (!ena) begin
        if (r < 40) ena = 1'b1;
      end else if (r == 50) begin
        ena = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
